// File: rtl/pmbist_addr_sequencer.sv
// rtl/pmbist_addr_sequencer.sv - PMBIST address counter with selectable address-ordering transform
module pmbist_addr_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  start_in,
    input  logic                  step_in,
    input  logic [1:0]            mode_in,
    input  logic [IDX_WIDTH-1:0]  i_in,
    input  logic                  updwn_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  addr_valid_out,
    output logic                  last_out,
    output logic                  done_out,
    output logic                  busy_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] T_MAX = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] t_q, t_d;
    logic [1:0]            mode_q, mode_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  dn_q, dn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    // Address-ordering transform; everything stays within W bits.
    function automatic logic [ADDR_WIDTH-1:0] xform(
        input logic [ADDR_WIDTH-1:0] t,
        input logic [1:0]            m,
        input logic [IDX_WIDTH-1:0]  idx
    );
        logic [ADDR_WIDTH-1:0] r;
        logic [ADDR_WIDTH-1:0] k;
        r = t;
        k = t >> 1;
        case (m)
            2'b00: begin
                // Swap bit 0 with bit idx; idx of 0 or beyond the width leaves t linear.
                for (int b = 1; b < ADDR_WIDTH; b++) begin
                    if (int'(idx) == b) begin
                        r[0] = t[b];
                        r[b] = t[0];
                    end
                end
            end
            2'b01:   r = t ^ k;
            2'b10:   r = t[0] ? ~k : k;
            default: r = t;
        endcase
        return r;
    endfunction

    // Final address depends on direction: top of space going up, zero going down.
    function automatic logic is_last(input logic [ADDR_WIDTH-1:0] t, input logic dn);
        return dn ? (t == '0) : (t == T_MAX);
    endfunction

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            mode_q  <= 2'b00;
            idx_q   <= '0;
            dn_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            dn_q    <= dn_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: start latches the configuration, steps walk the counter.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        dn_d    = dn_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                if (start_in) begin
                    state_d = ST_RUN;
                    mode_d  = mode_in;
                    idx_d   = i_in;
                    dn_d    = updwn_in;
                    t_d     = updwn_in ? T_MAX : '0;
                    addr_d  = xform(t_d, mode_in, i_in);
                    last_d  = is_last(t_d, updwn_in);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (step_in) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        t_d    = dn_q ? (t_q - 1'b1) : (t_q + 1'b1);
                        addr_d = xform(t_d, mode_q, idx_q);
                        last_d = is_last(t_d, dn_q);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign addr_out       = addr_q;
    assign addr_valid_out = valid_q;
    assign last_out       = last_q;
    assign done_out       = done_q;
    assign busy_out       = busy_q;

endmodule

// File: doc/pmbist_addr_sequencer.md
# pmbist_addr_sequencer

Parametrised, clocked address sequencer for the PMBIST engine. It owns the address counter and applies the selected address-ordering transform (2^i bit-swap, Gray code, address complement) to it. It walks the full 2^ADDR_WIDTH space up or down, one address per step request, and signals the last address and completion to the march-element controller. It replaces a fixed 8-bit combinational transform plus external counter with one width-generic sequential block.

## Interface
- ADDR_WIDTH, 8, address width W (2..16); sweep length is 2^W.
- IDX_WIDTH, 3, width of `i_in`; must satisfy 2^IDX_WIDTH >= ADDR_WIDTH.
- clk_in  input  1  single clock; all state updates on rising edge.
- rstn_in  input  1  reset, synchronous and active-low.
- start_in  input  1  begin a sweep; sampled only in IDLE.
- step_in  input  1  advance to next address; sampled only in RUN.
- mode_in  input  2  00 = 2^i, 01 = Gray code, 10 = address complement, 11 = reserved (treated as linear).
- i_in  input  IDX_WIDTH  bit index for 2^i mode.
- updwn_in  input  1  0 = up (counter from 0), 1 = down (counter from 2^W-1).
- addr_out  output  W  current transformed address, registered.
- addr_valid_out  output  1  addr_out is valid (high throughout RUN).
- last_out  output  1  addr_out is the final address of the sweep.
- done_out  output  1  one-cycle pulse after the final step.
- busy_out  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: start_in=1 latches mode_in, i_in and updwn_in. Counter t loads 0 (up) or 2^W-1 (down). Next state is RUN. Otherwise stay in IDLE.
- RUN with step_in=0: hold t and all outputs (stall).
- RUN with step_in=1 and last_out=0: t becomes t+1 (up) or t-1 (down). addr_out updates to T(new t).
- RUN with step_in=1 and last_out=1: go to DONE.
- DONE: done_out=1 for exactly one cycle, addr_valid_out=0, then IDLE.
- last_out=1 exactly when t equals 2^W-1 (up) or 0 (down).
- start_in is ignored outside IDLE. Changes on mode_in, i_in and updwn_in during RUN are ignored; the values latched at start are used.
- Transform T(t), W-bit, modulo 2^W, no carries out:
  - 2^i: t with bit 0 and bit i swapped. i=0, or i >= W, gives T(t)=t (linear).
  - Gray: t ^ (t >> 1).
  - Address complement: k = t >> 1 (MSB zero-filled). T = k if t[0]=0, else ~k.
  - Reserved: T(t)=t.
- Reset (rstn_in=0 on a rising edge) mid-sweep aborts immediately: IDLE, outputs at reset values, no done_out pulse.

## Timing
- Reset values: addr_out=0, addr_valid_out=0, last_out=0, done_out=0, busy_out=0.
- start_in high at edge N: from N+1, addr_valid_out=1, busy_out=1, addr_out=T(t0), last_out valid.
- step_in high at edge M in RUN: the next address and last_out appear from M+1. One address per cycle when step_in is held high.
- Final step at edge F: from F+1, done_out=1, addr_valid_out=0, busy_out=1. From F+2, IDLE with busy_out=0. The earliest new start_in is sampled at edge F+2.
- addr_out keeps its last value in DONE and IDLE.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.
- A full sweep with continuous stepping takes 2^W+2 cycles from start_in to return to IDLE.

## Test plan
- W=8, mode 00, i=0, up, step_in held high → addr_out 0,1,…,255; last_out only with 255; done_out pulse one cycle later; busy_out low the cycle after that.
- W=4, Gray, up → 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Down → the same sequence reversed, starting at 8.
- W=4, address complement, up → 0,15,1,14,2,13,…,7,8 with last_out on 8. Down → starts 8,7 and ends 15,0.
- W=4, 2^i with i=2, up → 0,4,2,6,1,5,3,7,8,12,…. With i=5 (>= W) → linear 0..15.
- Stalls and ignored inputs: toggle step_in randomly → addr_out holds on every step_in=0 cycle. Change mode_in and updwn_in mid-RUN, and pulse start_in mid-RUN → no effect on the sequence.
- Reset mid-sweep at t=5 → next cycle all outputs 0, no done_out. A fresh start_in then restarts from t0.
